pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined control and hazard unit for the five-stage RISC-V core. It decodes the ID-stage opcode into a control bundle and carries that bundle through its own ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use and branch-operand hazards, inserts bubbles, flushes IF/ID on taken branches and jumps, generates EX-stage forwarding selects, and freezes on data-memory back-pressure. It replaces the flat decoder-plus-NoOp arrangement and sits between the IF/ID register and the datapath stage registers.

## Interface
Parameters:
- RAW, 5, register address width.
- ALUOP_W, 2, ALUOp field width.
- EXT_ISA, 1, 1 = decode jal and lui; 0 = those opcodes decode as NOP.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- op_i  in  7  ID opcode.
- rs1_i, rs2_i, rd_i  in  RAW each  ID register fields.
- eq_i  in  1  ID register-compare result (rs1 == rs2).
- mem_stall_i  in  1  data memory busy; freeze whole pipeline.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  zero IF/ID on next edge.
- id_jump_o  out  1  jal in ID (PC target select).
- ex_aluop_o  out  ALUOP_W  ALUOp in EX.
- ex_alusrc_o  out  1  ALU source select in EX.
- fwd_a_o, fwd_b_o  out  2 each  EX operand forwarding select.
- mem_read_o, mem_write_o  out  1 each  data-memory strobes in MEM.
- wb_regwrite_o  out  1  register-file write enable in WB.
- wb_sel_o  out  2  WB source select.
- wb_rd_o  out  RAW  WB destination register.

## Operation
Decode (combinational, ID stage):
- R 0110011: aluop 10, alusrc 0, regwrite 1, wb 00; uses rs1 and rs2.
- I 0010011: aluop 11, alusrc 1, regwrite 1, wb 00; uses rs1.
- lw 0000011: aluop 00, alusrc 1, regwrite 1, memread 1, wb 01; uses rs1.
- sw 0100011: aluop 00, alusrc 1, memwrite 1; uses rs1 and rs2.
- beq 1100011: aluop 01, branch 1; uses rs1 and rs2.
- jal 1101111 (EXT_ISA): jump 1, regwrite 1, wb 10 (PC+4); uses no sources.
- lui 0110111 (EXT_ISA): aluop 00, alusrc 1, regwrite 1, wb 00; uses no sources.
- Any other opcode: all-zero bundle, treated as NOP.

Hazards:
- A source is live only if the opcode uses it and its register field is nonzero.
- load_use: EX.memread && EX.rd == a live source.
- br_haz: ID is beq, and either (EX.regwrite && EX.rd == a live source) or (MEM.memread && MEM.rd == a live source).
- stall = load_use | br_haz.

Priority (highest first):
1. mem_stall_i: all control registers hold; pc_write_o = ifid_write_o = 0; ifid_flush_o = 0.
2. stall: ID/EX loads an all-zero bundle with rd = 0; pc_write_o = ifid_write_o = 0; ifid_flush_o = 0.
3. Otherwise pc_write_o = ifid_write_o = 1, and ifid_flush_o = (beq && eq_i) | jump.

Forwarding (fwd_a_o shown; fwd_b_o is identical using EX.rs2):
- 10 if MEM.regwrite && MEM.rd != 0 && MEM.rd == EX.rs1.
- else 01 if WB.regwrite && WB.rd != 0 && WB.rd == EX.rs1.
- else 00.
- The MEM stage wins when MEM and WB both match.
- The ID/EX register stores rs1/rs2 for this purpose; bubbles store 0.

## Timing
- Decode, hazard detection and forwarding are combinational, with zero-cycle latency to pc_write_o, ifid_*, id_jump_o and fwd_*.
- Stage outputs are registered: an instruction decoded in cycle n shows its EX fields in n+1, MEM fields in n+2, WB fields in n+3 (absent freezes).
- Reset clears every control register to zero immediately, without waiting for a clock edge. While reset is held:
  - All registered outputs read 0.
  - fwd_*_o read 00.
  - pc_write_o/ifid_write_o follow the combinational rules, so they read 1 with no stall.
- A load-use hazard costs exactly one bubble. A br_haz caused by an EX ALU result costs one bubble; when EX holds a load, two bubbles.
- Simultaneous mem_stall_i and stall: freeze only, no bubble. The stall condition is re-evaluated when the freeze releases.
- Taken beq while stalled: no flush that cycle; the flush is issued in the cycle the stall clears.
- Reset asserted mid-freeze or mid-stall: all in-flight control is discarded.

## Structure
- Shared package ctrl_pkg holds:
  - opcode constants;
  - ALUOp encodings (00 add, 01 sub/branch, 10 R, 11 I);
  - wb_sel encodings (00 ALU, 01 mem, 10 PC+4);
  - forwarding encodings;
  - the packed control-bundle struct.
- Sub-module ctrl_decoder holds the combinational opcode-to-bundle decode and the rs-use flags, parameterised by EXT_ISA.
- Hazard logic, forwarding logic and the three control registers live in pipe_ctrl_unit.

## Test plan
- Reset, then R-type op 0110011 with rd = 3: ex_aluop_o = 10 after 1 cycle, wb_regwrite_o = 1 and wb_rd_o = 3 after 3 cycles.
- lw x5, then add x6, x5, x1: one cycle with pc_write_o = 0 and ifid_write_o = 0, a bubble in EX, then fwd_a_o = 01 when add reaches EX.
- add x7, then beq x7, x7 with eq_i = 1: one stall cycle, then ifid_flush_o = 1 for exactly one cycle.
- mem_stall_i held 3 cycles with an sw in MEM: mem_write_o stays 1, the EX and WB fields stay unchanged, pc_write_o = 0 throughout.
- add writing x0 followed by a consumer of x0: fwd_a_o = fwd_b_o = 00, no stall.
- With EXT_ISA = 0, op 1101111: all stage outputs 0 and id_jump_o = 0. With EXT_ISA = 1: id_jump_o = 1, ifid_flush_o = 1, and wb_sel_o = 10 three cycles later.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcodes, select encodings
// and the per-stage control bundles that peel off as an instruction advances.
package ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_R   = 2'b10,
    ALU_I   = 2'b11
  } aluOpE;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wbSelE;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwdSelE;

  // Nested so each stage register keeps only the fields still needed downstream.
  typedef struct packed {
    logic  regWrite;
    wbSelE wbSel;
  } wbCtrlT;

  typedef struct packed {
    logic   memRead;
    logic   memWrite;
    wbCtrlT wb;
  } memCtrlT;

  typedef struct packed {
    aluOpE   aluOp;
    logic    aluSrc;
    memCtrlT mem;
  } exCtrlT;

  typedef struct packed {
    logic   branch;
    logic   jump;
    exCtrlT ex;
  } ctrlBundleT;

  // The nearer producer (MEM) carries the newer value, so it wins over WB.
  function automatic fwdSelE fwdSelect(input logic memHit, input logic wbHit);
    if (memHit)     return FWD_MEM;
    else if (wbHit) return FWD_WB;
    else            return FWD_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Handshake between the ID-stage datapath and the control unit: decoded fields in,
// stall/flush/forwarding controls and per-stage control bundles out.
interface pipe_ctrl_unit_if #(
  parameter int RAW     = 5,
  parameter int ALUOP_W = 2
);
  logic [6:0]         op_i;
  logic [RAW-1:0]     rs1_i;
  logic [RAW-1:0]     rs2_i;
  logic [RAW-1:0]     rd_i;
  logic               eq_i;
  logic               mem_stall_i;

  logic               pc_write_o;
  logic               ifid_write_o;
  logic               ifid_flush_o;
  logic               id_jump_o;
  logic [ALUOP_W-1:0] ex_aluop_o;
  logic               ex_alusrc_o;
  logic [1:0]         fwd_a_o;
  logic [1:0]         fwd_b_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic               wb_regwrite_o;
  logic [1:0]         wb_sel_o;
  logic [RAW-1:0]     wb_rd_o;

  // Datapath side: supplies ID fields, consumes controls.
  modport master (
    output op_i, rs1_i, rs2_i, rd_i, eq_i, mem_stall_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, id_jump_o,
           ex_aluop_o, ex_alusrc_o, fwd_a_o, fwd_b_o,
           mem_read_o, mem_write_o, wb_regwrite_o, wb_sel_o, wb_rd_o
  );

  // Control-unit side.
  modport slave (
    input  op_i, rs1_i, rs2_i, rd_i, eq_i, mem_stall_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, id_jump_o,
           ex_aluop_o, ex_alusrc_o, fwd_a_o, fwd_b_o,
           mem_read_o, mem_write_o, wb_regwrite_o, wb_sel_o, wb_rd_o
  );
endinterface

// File: rtl/ctrl_decoder.sv
// ID-stage opcode decode into the control bundle plus source-register use flags.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter bit EXT_ISA = 1'b1
) (
  input  logic [6:0] op,
  output ctrlBundleT ctrl,
  output logic       usesRs1,
  output logic       usesRs2
);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    ctrl    = '0;
    usesRs1 = 1'b0;
    usesRs2 = 1'b0;
    case (op)
      OP_R: begin
        ctrl.ex.aluOp           = ALU_R;
        ctrl.ex.mem.wb.regWrite = 1'b1;
        usesRs1                 = 1'b1;
        usesRs2                 = 1'b1;
      end
      OP_I: begin
        ctrl.ex.aluOp           = ALU_I;
        ctrl.ex.aluSrc          = 1'b1;
        ctrl.ex.mem.wb.regWrite = 1'b1;
        usesRs1                 = 1'b1;
      end
      OP_LW: begin
        ctrl.ex.aluOp           = ALU_ADD;
        ctrl.ex.aluSrc          = 1'b1;
        ctrl.ex.mem.memRead     = 1'b1;
        ctrl.ex.mem.wb.regWrite = 1'b1;
        ctrl.ex.mem.wb.wbSel    = WB_MEM;
        usesRs1                 = 1'b1;
      end
      OP_SW: begin
        ctrl.ex.aluOp           = ALU_ADD;
        ctrl.ex.aluSrc          = 1'b1;
        ctrl.ex.mem.memWrite    = 1'b1;
        usesRs1                 = 1'b1;
        usesRs2                 = 1'b1;
      end
      OP_BEQ: begin
        ctrl.ex.aluOp           = ALU_SUB;
        ctrl.branch             = 1'b1;
        usesRs1                 = 1'b1;
        usesRs2                 = 1'b1;
      end
      OP_JAL: begin
        if (EXT_ISA) begin
          ctrl.jump               = 1'b1;
          ctrl.ex.mem.wb.regWrite = 1'b1;
          ctrl.ex.mem.wb.wbSel    = WB_PC4;
        end
      end
      OP_LUI: begin
        if (EXT_ISA) begin
          ctrl.ex.aluOp           = ALU_ADD;
          ctrl.ex.aluSrc          = 1'b1;
          ctrl.ex.mem.wb.regWrite = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control and hazard unit: decodes in ID, carries control through
// ID/EX, EX/MEM, MEM/WB, and produces stall, flush and EX forwarding selects.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int RAW     = 5,
  parameter int ALUOP_W = 2,
  parameter bit EXT_ISA = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pipe_ctrl_unit_if.slave bus
);

  ctrlBundleT idCtrl;
  logic       usesRs1;
  logic       usesRs2;

  ctrl_decoder #(.EXT_ISA(EXT_ISA)) uDecoder (
    .op      (bus.op_i),
    .ctrl    (idCtrl),
    .usesRs1 (usesRs1),
    .usesRs2 (usesRs2)
  );

  exCtrlT         exCtrl;
  logic [RAW-1:0] exRd;
  logic [RAW-1:0] exRs1;
  logic [RAW-1:0] exRs2;
  memCtrlT        memCtrl;
  logic [RAW-1:0] memRd;
  wbCtrlT         wbCtrl;
  logic [RAW-1:0] wbRd;

  // A source is live only when the opcode reads it and it is not x0.
  logic rs1Live;
  logic rs2Live;
  logic exHitsSrc;
  logic memHitsSrc;
  logic loadUse;
  logic brHaz;
  logic stall;
  logic advance;

  assign rs1Live    = usesRs1 && (bus.rs1_i != '0);
  assign rs2Live    = usesRs2 && (bus.rs2_i != '0);
  assign exHitsSrc  = (rs1Live && (exRd  == bus.rs1_i)) || (rs2Live && (exRd  == bus.rs2_i));
  assign memHitsSrc = (rs1Live && (memRd == bus.rs1_i)) || (rs2Live && (memRd == bus.rs2_i));

  // beq compares in ID, so it must also wait for an ALU result still in EX and
  // for load data that has not yet left MEM.
  assign loadUse = exCtrl.mem.memRead && exHitsSrc;
  assign brHaz   = idCtrl.branch &&
                   ((exCtrl.mem.wb.regWrite && exHitsSrc) || (memCtrl.memRead && memHitsSrc));
  assign stall   = loadUse || brHaz;
  assign advance = !bus.mem_stall_i && !stall;

  assign bus.pc_write_o   = advance;
  assign bus.ifid_write_o = advance;
  assign bus.ifid_flush_o = advance && ((idCtrl.branch && bus.eq_i) || idCtrl.jump);
  assign bus.id_jump_o    = idCtrl.jump;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: these are a handful of flops rather than a memory, so all get the async reset.
      exCtrl  <= '0;
      exRd    <= '0;
      exRs1   <= '0;
      exRs2   <= '0;
      memCtrl <= '0;
      memRd   <= '0;
      wbCtrl  <= '0;
      wbRd    <= '0;
    end else if (!bus.mem_stall_i) begin
      // NOTE: non-blocking, so each stage captures the pre-edge value of the stage before it.
      if (stall) begin
        exCtrl <= '0;
        exRd   <= '0;
        exRs1  <= '0;
        exRs2  <= '0;
      end else begin
        exCtrl <= idCtrl.ex;
        exRd   <= bus.rd_i;
        exRs1  <= bus.rs1_i;
        exRs2  <= bus.rs2_i;
      end
      memCtrl <= exCtrl.mem;
      memRd   <= exRd;
      wbCtrl  <= memCtrl.wb;
      wbRd    <= memRd;
    end
  end

  logic memWritesReg;
  logic wbWritesReg;

  assign memWritesReg = memCtrl.wb.regWrite && (memRd != '0);
  assign wbWritesReg  = wbCtrl.regWrite && (wbRd != '0);

  assign bus.fwd_a_o = fwdSelect(memWritesReg && (memRd == exRs1), wbWritesReg && (wbRd == exRs1));
  assign bus.fwd_b_o = fwdSelect(memWritesReg && (memRd == exRs2), wbWritesReg && (wbRd == exRs2));

  assign bus.ex_aluop_o    = ALUOP_W'(exCtrl.aluOp);
  assign bus.ex_alusrc_o   = exCtrl.aluSrc;
  assign bus.mem_read_o    = memCtrl.memRead;
  assign bus.mem_write_o   = memCtrl.memWrite;
  assign bus.wb_regwrite_o = wbCtrl.regWrite;
  assign bus.wb_sel_o      = wbCtrl.wbSel;
  assign bus.wb_rd_o       = wbRd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench: two units (EXT_ISA = 1 and 0) share one stimulus stream; a
// queue-of-instructions reference model predicts every output each cycle.
module tb_pipe_ctrl_unit;

  localparam int RAW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.RAW(RAW), .ALUOP_W(2)) busX ();
  pipe_ctrl_unit_if #(.RAW(RAW), .ALUOP_W(2)) busB ();

  pipe_ctrl_unit #(.RAW(RAW), .ALUOP_W(2), .EXT_ISA(1'b1)) dutExt (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busX)
  );

  pipe_ctrl_unit #(.RAW(RAW), .ALUOP_W(2), .EXT_ISA(1'b0)) dutBase (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busB)
  );

  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instT;

  typedef struct packed {
    logic       regW, memR, memW, branch, jump, useA, useB, aluSrc;
    logic [1:0] aluOp;
    logic [1:0] wbSel;
  } decT;

  typedef struct packed {
    logic       pcWrite, ifidWrite, ifidFlush, idJump;
    logic [1:0] aluOp;
    logic       aluSrc;
    logic [1:0] fwdA, fwdB;
    logic       memRead, memWrite, regWrite;
    logic [1:0] wbSel;
    logic [4:0] wbRd;
  } outT;

  // Model state per unit: instructions currently in EX (0), MEM (1), WB (2).
  instT pipe [2][3];
  outT  expQ0[$];
  outT  expQ1[$];
  outT  lastOut;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  function automatic decT dec(input logic [6:0] op, input bit ext);
    decT d = '0;
    case (op)
      7'b0110011: begin d.aluOp = 2'b10; d.regW = 1; d.useA = 1; d.useB = 1; end
      7'b0010011: begin d.aluOp = 2'b11; d.aluSrc = 1; d.regW = 1; d.useA = 1; end
      7'b0000011: begin d.aluSrc = 1; d.regW = 1; d.memR = 1; d.wbSel = 2'b01; d.useA = 1; end
      7'b0100011: begin d.aluSrc = 1; d.memW = 1; d.useA = 1; d.useB = 1; end
      7'b1100011: begin d.aluOp = 2'b01; d.branch = 1; d.useA = 1; d.useB = 1; end
      7'b1101111: if (ext) begin d.jump = 1; d.regW = 1; d.wbSel = 2'b10; end
      7'b0110111: if (ext) begin d.aluSrc = 1; d.regW = 1; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic instT mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    instT i;
    i.op  = op;
    i.rd  = 5'(rd);
    i.rs1 = 5'(rs1);
    i.rs2 = 5'(rs2);
    return i;
  endfunction

  function automatic logic readsReg(input instT i, input decT d, input logic [4:0] r);
    return (d.useA && i.rs1 != 0 && i.rs1 == r) || (d.useB && i.rs2 != 0 && i.rs2 == r);
  endfunction

  function automatic logic [1:0] fwdFor(input logic [4:0] src, input instT m, input instT w, input bit ext);
    if (dec(m.op, ext).regW && m.rd != 0 && m.rd == src) return 2'b10;
    if (dec(w.op, ext).regW && w.rd != 0 && w.rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic outT predict(input int k, input instT id, input logic eq, input logic ms, input bit ext);
    outT  o;
    instT ex  = pipe[k][0];
    instT mem = pipe[k][1];
    instT wb  = pipe[k][2];
    decT  dI  = dec(id.op, ext);
    decT  dE  = dec(ex.op, ext);
    decT  dM  = dec(mem.op, ext);
    decT  dW  = dec(wb.op, ext);
    logic loadUse = dE.memR && readsReg(id, dI, ex.rd);
    logic brHaz   = dI.branch && ((dE.regW && readsReg(id, dI, ex.rd)) ||
                                  (dM.memR && readsReg(id, dI, mem.rd)));
    logic go      = !ms && !(loadUse || brHaz);
    o.pcWrite   = go;
    o.ifidWrite = go;
    o.ifidFlush = go && ((dI.branch && eq) || dI.jump);
    o.idJump    = dI.jump;
    o.aluOp     = dE.aluOp;
    o.aluSrc    = dE.aluSrc;
    o.fwdA      = fwdFor(ex.rs1, mem, wb, ext);
    o.fwdB      = fwdFor(ex.rs2, mem, wb, ext);
    o.memRead   = dM.memR;
    o.memWrite  = dM.memW;
    o.regWrite  = dW.regW;
    o.wbSel     = dW.wbSel;
    o.wbRd      = wb.rd;
    return o;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle %0d %s: got %0h expected %0h", cycle, name, act, exp);
    end
  endtask

  task automatic compareOut(input string tag, input outT a, input outT e);
    check({tag, ".pc_write"},   8'(a.pcWrite),   8'(e.pcWrite));
    check({tag, ".ifid_write"}, 8'(a.ifidWrite), 8'(e.ifidWrite));
    check({tag, ".ifid_flush"}, 8'(a.ifidFlush), 8'(e.ifidFlush));
    check({tag, ".id_jump"},    8'(a.idJump),    8'(e.idJump));
    check({tag, ".ex_aluop"},   8'(a.aluOp),     8'(e.aluOp));
    check({tag, ".ex_alusrc"},  8'(a.aluSrc),    8'(e.aluSrc));
    check({tag, ".fwd_a"},      8'(a.fwdA),      8'(e.fwdA));
    check({tag, ".fwd_b"},      8'(a.fwdB),      8'(e.fwdB));
    check({tag, ".mem_read"},   8'(a.memRead),   8'(e.memRead));
    check({tag, ".mem_write"},  8'(a.memWrite),  8'(e.memWrite));
    check({tag, ".wb_regwrite"},8'(a.regWrite),  8'(e.regWrite));
    check({tag, ".wb_sel"},     8'(a.wbSel),     8'(e.wbSel));
    check({tag, ".wb_rd"},      8'(a.wbRd),      8'(e.wbRd));
  endtask

  // Monitor: outputs are stable mid-cycle, so sample on the falling edge.
  always @(negedge clk) begin
    outT a;
    outT e;
    if (expQ0.size() > 0) begin
      e = expQ0.pop_front();
      a.pcWrite = busX.pc_write_o;   a.ifidWrite = busX.ifid_write_o;
      a.ifidFlush = busX.ifid_flush_o; a.idJump = busX.id_jump_o;
      a.aluOp = busX.ex_aluop_o;     a.aluSrc = busX.ex_alusrc_o;
      a.fwdA = busX.fwd_a_o;         a.fwdB = busX.fwd_b_o;
      a.memRead = busX.mem_read_o;   a.memWrite = busX.mem_write_o;
      a.regWrite = busX.wb_regwrite_o; a.wbSel = busX.wb_sel_o;
      a.wbRd = busX.wb_rd_o;
      compareOut("ext", a, e);
    end
    if (expQ1.size() > 0) begin
      e = expQ1.pop_front();
      a.pcWrite = busB.pc_write_o;   a.ifidWrite = busB.ifid_write_o;
      a.ifidFlush = busB.ifid_flush_o; a.idJump = busB.id_jump_o;
      a.aluOp = busB.ex_aluop_o;     a.aluSrc = busB.ex_alusrc_o;
      a.fwdA = busB.fwd_a_o;         a.fwdB = busB.fwd_b_o;
      a.memRead = busB.mem_read_o;   a.memWrite = busB.mem_write_o;
      a.regWrite = busB.wb_regwrite_o; a.wbSel = busB.wb_sel_o;
      a.wbRd = busB.wb_rd_o;
      compareOut("base", a, e);
    end
    cycle++;
  end

  // One clock of stimulus: drive both units, push predictions, advance the model.
  task automatic step(input instT id, input logic eq, input logic ms, input logic r);
    outT o;
    @(posedge clk);
    #1;
    rst = r;
    busX.op_i = id.op; busX.rd_i = id.rd; busX.rs1_i = id.rs1; busX.rs2_i = id.rs2;
    busX.eq_i = eq;    busX.mem_stall_i = ms;
    busB.op_i = id.op; busB.rd_i = id.rd; busB.rs1_i = id.rs1; busB.rs2_i = id.rs2;
    busB.eq_i = eq;    busB.mem_stall_i = ms;
    for (int k = 0; k < 2; k++) begin
      if (r) for (int s = 0; s < 3; s++) pipe[k][s] = '0;
      o = predict(k, id, eq, ms, k == 0);
      if (k == 0) begin
        expQ0.push_back(o);
        lastOut = o;
      end else begin
        expQ1.push_back(o);
      end
      if (!r && !ms) begin
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = pipe[k][0];
        pipe[k][0] = o.pcWrite ? id : '0;
      end
    end
  endtask

  // Present an instruction in ID and hold it there while the unit stalls.
  task automatic issue(input instT i, input logic eq);
    int n = 0;
    do begin
      step(i, eq, 1'b0, 1'b0);
      n++;
    end while (!lastOut.pcWrite && n < 8);
  endtask

  localparam logic [6:0] R = 7'b0110011, IMM = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, LUI = 7'b0110111;

  initial begin
    instT nop;
    instT cur;
    logic [6:0] opTab [9];
    nop = '0;
    lastOut = '0;
    for (int k = 0; k < 2; k++) for (int s = 0; s < 3; s++) pipe[k][s] = '0;
    busX.op_i = '0; busX.rd_i = '0; busX.rs1_i = '0; busX.rs2_i = '0; busX.eq_i = 0; busX.mem_stall_i = 0;
    busB.op_i = '0; busB.rd_i = '0; busB.rs1_i = '0; busB.rs2_i = '0; busB.eq_i = 0; busB.mem_stall_i = 0;

    // Reset held, then R-type to x3 walking through the stages.
    step(nop, 0, 0, 1);
    step(nop, 0, 1, 1);
    issue(mk(R, 3, 1, 2), 0);
    repeat (4) issue(nop, 0);

    // Load-use, then a branch behind an ALU result and behind a load.
    issue(mk(LW, 5, 1, 0), 0);
    issue(mk(R, 6, 5, 1), 0);
    repeat (3) issue(nop, 0);
    issue(mk(R, 7, 1, 2), 0);
    issue(mk(BEQ, 0, 7, 7), 1);
    issue(nop, 0);
    issue(mk(LW, 9, 1, 0), 0);
    issue(mk(BEQ, 0, 9, 2), 1);
    repeat (3) issue(nop, 0);

    // Freeze with a store in MEM, and a freeze that coincides with a load-use.
    issue(mk(SW, 0, 1, 2), 0);
    issue(mk(LW, 4, 2, 0), 0);
    step(mk(R, 8, 4, 4), 0, 1, 0);
    step(mk(R, 8, 4, 4), 0, 1, 0);
    step(mk(R, 8, 4, 4), 0, 1, 0);
    issue(mk(R, 8, 4, 4), 0);
    repeat (3) issue(nop, 0);

    // Writes to x0 never forward or stall; jal and lui differ between the two units.
    issue(mk(R, 0, 1, 2), 0);
    issue(mk(R, 4, 0, 0), 0);
    issue(mk(JAL, 1, 0, 0), 0);
    issue(mk(LUI, 2, 3, 4), 0);
    issue(mk(BEQ, 0, 2, 2), 1);
    repeat (4) issue(nop, 0);

    // Reset in the middle of a freeze.
    issue(mk(LW, 5, 1, 0), 0);
    step(mk(R, 6, 5, 5), 0, 1, 0);
    step(mk(R, 6, 5, 5), 0, 1, 1);
    step(mk(R, 6, 5, 5), 0, 0, 0);

    // Randomized stream; ID holds while stalled and is zeroed after a flush.
    opTab = '{R, IMM, LW, SW, BEQ, JAL, LUI, 7'b1111111, 7'b0000000};
    cur = nop;
    for (int n = 0; n < 3000; n++) begin
      logic ms;
      logic r;
      if (lastOut.ifidWrite) begin
        if (lastOut.ifidFlush) cur = nop;
        else cur = mk(opTab[$urandom_range(0, 8)], $urandom_range(0, 5),
                      $urandom_range(0, 5), $urandom_range(0, 5));
      end
      ms = ($urandom_range(0, 99) < 12);
      r  = ($urandom_range(0, 299) == 0);
      step(cur, 1'($urandom_range(0, 1)), ms, r);
    end

    @(negedge clk);
    #1;
    check("queue_drain", 8'(expQ0.size() + expQ1.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
